// File: rtl/ahb_master_arbiter.sv
// Two-master AHB arbiter: round-robin with bus parking, fixed-burst and lock
// protection, plus the shared address-phase and write-data multiplexers.
module ahb_master_arbiter #(
    parameter int unsigned AW             = 36,
    parameter int unsigned DW             = 64,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic          HCLK,
    input  logic          SysRST,
    input  logic          HBUSREQ0,
    input  logic          HBUSREQ1,
    input  logic          HLOCK0,
    input  logic          HLOCK1,
    input  logic [AW-1:0] HADDR0,
    input  logic [AW-1:0] HADDR1,
    input  logic [1:0]    HTRANS0,
    input  logic [1:0]    HTRANS1,
    input  logic          HWRITE0,
    input  logic          HWRITE1,
    input  logic [2:0]    HSIZE0,
    input  logic [2:0]    HSIZE1,
    input  logic [2:0]    HBURST0,
    input  logic [2:0]    HBURST1,
    input  logic [3:0]    HPROT0,
    input  logic [3:0]    HPROT1,
    input  logic [DW-1:0] HWDATA0,
    input  logic [DW-1:0] HWDATA1,
    output logic          HGRANT0,
    output logic          HGRANT1,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic [DW-1:0] HWDATA,
    output logic          HMASTLOCK,
    output logic          HMASTER,
    output logic          HMASTER_D,
    input  logic          HREADY,
    input  logic [1:0]    HRESP
);

    localparam int unsigned BW           = 5;
    localparam logic        DEF_M        = 1'(DEFAULT_MASTER);
    localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
    localparam logic [1:0]  TRANS_SEQ    = 2'b11;
    localparam logic [1:0]  RESP_ERROR   = 2'b01;

    logic [1:0]    hgrant_q, hgrant_d;
    logic          aowner_q, aowner_d;
    logic          downer_q, downer_d;
    logic          mastlock_q, mastlock_d;
    logic [BW-1:0] beats_q, beats_d;
    logic          last_q, last_d;

    logic          gnt_idx;
    logic          lock_gnt;
    logic          rearb_ok;
    logic          win;

    // Remaining beats after a NONSEQ: INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16
    function automatic logic [BW-1:0] burst_len(input logic [1:0] burst_hi);
        case (burst_hi)
            2'b01:   return BW'(3);
            2'b10:   return BW'(7);
            2'b11:   return BW'(15);
            default: return BW'(0);
        endcase
    endfunction

    assign gnt_idx  = hgrant_q[1];
    assign lock_gnt = gnt_idx ? HLOCK1 : HLOCK0;

    // Beat tracking and round-robin arbitration for the next HREADY=1 edge
    always_comb begin
        beats_d    = beats_q;
        last_d     = last_q;
        win        = gnt_idx;
        rearb_ok   = 1'b0;
        aowner_d   = gnt_idx;
        downer_d   = aowner_q;
        mastlock_d = lock_gnt;

        if (HTRANS == TRANS_NONSEQ) begin
            beats_d = burst_len(HBURST[2:1]);
        end else if (HTRANS == TRANS_SEQ && beats_q != '0) begin
            beats_d = beats_q - BW'(1);
        end

        rearb_ok = (beats_d == '0) && !lock_gnt;

        if (rearb_ok) begin
            if (HBUSREQ0 && HBUSREQ1) begin
                win    = ~last_q;
                last_d = ~last_q;
            end else if (HBUSREQ0) begin
                win    = 1'b0;
                last_d = 1'b0;
            end else if (HBUSREQ1) begin
                win    = 1'b1;
                last_d = 1'b1;
            end else begin
                win    = DEF_M;
            end
        end

        hgrant_d = {win, ~win};
    end

    // Wait states freeze everything except the ERROR burst cancel
    always_ff @(posedge HCLK) begin
        if (SysRST) begin
            hgrant_q   <= DEF_M ? 2'b10 : 2'b01;
            aowner_q   <= DEF_M;
            downer_q   <= DEF_M;
            mastlock_q <= 1'b0;
            beats_q    <= '0;
            last_q     <= DEF_M;
        end else if (HREADY) begin
            hgrant_q   <= hgrant_d;
            aowner_q   <= aowner_d;
            downer_q   <= downer_d;
            mastlock_q <= mastlock_d;
            beats_q    <= beats_d;
            last_q     <= last_d;
        end else if (HRESP == RESP_ERROR) begin
            beats_q    <= '0;
        end
    end

    assign HGRANT0   = hgrant_q[0];
    assign HGRANT1   = hgrant_q[1];
    assign HMASTER   = aowner_q;
    assign HMASTER_D = downer_q;
    assign HMASTLOCK = mastlock_q;

    // Shared bus muxes driven from the registered owners
    always_comb begin
        HADDR  = aowner_q ? HADDR1  : HADDR0;
        HTRANS = aowner_q ? HTRANS1 : HTRANS0;
        HWRITE = aowner_q ? HWRITE1 : HWRITE0;
        HSIZE  = aowner_q ? HSIZE1  : HSIZE0;
        HBURST = aowner_q ? HBURST1 : HBURST0;
        HPROT  = aowner_q ? HPROT1  : HPROT0;
        HWDATA = downer_q ? HWDATA1 : HWDATA0;
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: reset, handover, round-robin,
// burst protection, locking and ERROR cancel, with hand-computed expectations.
module tb_ahb_master_arbiter;

    logic        HCLK;
    logic        SysRST;
    logic        HBUSREQ0, HBUSREQ1, HLOCK0, HLOCK1;
    logic [35:0] HADDR0, HADDR1;
    logic [1:0]  HTRANS0, HTRANS1;
    logic        HWRITE0, HWRITE1;
    logic [2:0]  HSIZE0, HSIZE1, HBURST0, HBURST1;
    logic [3:0]  HPROT0, HPROT1;
    logic [63:0] HWDATA0, HWDATA1;
    logic        HGRANT0, HGRANT1;
    logic [35:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [63:0] HWDATA;
    logic        HMASTLOCK, HMASTER, HMASTER_D;
    logic        HREADY;
    logic [1:0]  HRESP;

    int errors = 0;
    int checks = 0;

    ahb_master_arbiter #(.AW(36), .DW(64), .DEFAULT_MASTER(0)) dut (
        .HCLK(HCLK), .SysRST(SysRST),
        .HBUSREQ0(HBUSREQ0), .HBUSREQ1(HBUSREQ1),
        .HLOCK0(HLOCK0), .HLOCK1(HLOCK1),
        .HADDR0(HADDR0), .HADDR1(HADDR1),
        .HTRANS0(HTRANS0), .HTRANS1(HTRANS1),
        .HWRITE0(HWRITE0), .HWRITE1(HWRITE1),
        .HSIZE0(HSIZE0), .HSIZE1(HSIZE1),
        .HBURST0(HBURST0), .HBURST1(HBURST1),
        .HPROT0(HPROT0), .HPROT1(HPROT1),
        .HWDATA0(HWDATA0), .HWDATA1(HWDATA1),
        .HGRANT0(HGRANT0), .HGRANT1(HGRANT1),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HWDATA(HWDATA), .HMASTLOCK(HMASTLOCK),
        .HMASTER(HMASTER), .HMASTER_D(HMASTER_D),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge HCLK);
        #2;
    endtask

    task automatic do_reset();
        SysRST   = 1'b1;
        HBUSREQ0 = 1'b0; HBUSREQ1 = 1'b0; HLOCK0 = 1'b0; HLOCK1 = 1'b0;
        HADDR0   = '0;   HADDR1   = '0;   HTRANS0 = 2'b00; HTRANS1 = 2'b00;
        HWRITE0  = 1'b0; HWRITE1  = 1'b0; HSIZE0 = 3'd3; HSIZE1 = 3'd3;
        HBURST0  = 3'd0; HBURST1  = 3'd0; HPROT0 = 4'h3; HPROT1 = 4'h3;
        HWDATA0  = '0;   HWDATA1  = '0;   HREADY = 1'b1; HRESP = 2'b00;
        cyc();
        cyc();
        SysRST   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        HTRANS0 = 2'b10; HTRANS1 = 2'b01;
        #1;
        checks++; if (HGRANT0 !== 1'b1) begin errors++; $display("FAIL reset_hgrant0: got %b expected 1", HGRANT0); end
        checks++; if (HGRANT1 !== 1'b0) begin errors++; $display("FAIL reset_hgrant1: got %b expected 0", HGRANT1); end
        checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL reset_hmaster: got %b expected 0", HMASTER); end
        checks++; if (HMASTER_D !== 1'b0) begin errors++; $display("FAIL reset_hmaster_d: got %b expected 0", HMASTER_D); end
        checks++; if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL reset_hmastlock: got %b expected 0", HMASTLOCK); end
        checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL reset_htrans: got %b expected 10", HTRANS); end
        HTRANS0 = 2'b00; HTRANS1 = 2'b00;
    endtask

    task automatic test_single_request();
        do_reset();
        HBUSREQ1 = 1'b1; HTRANS1 = 2'b10; HADDR1 = 36'h200000000; HWRITE1 = 1'b1;
        HBURST1  = 3'd0; HWDATA1 = 64'hDEADBEEF_00000001; HWDATA0 = 64'h1111_2222_3333_4444;
        HADDR0   = 36'h000000040;
        cyc();
        checks++; if (HGRANT1 !== 1'b1) begin errors++; $display("FAIL single_grant1: got %b expected 1", HGRANT1); end
        checks++; if (HGRANT0 !== 1'b0) begin errors++; $display("FAIL single_grant0: got %b expected 0", HGRANT0); end
        checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL single_hmaster_k: got %b expected 0", HMASTER); end
        cyc();
        checks++; if (HMASTER !== 1'b1) begin errors++; $display("FAIL single_hmaster_k1: got %b expected 1", HMASTER); end
        checks++; if (HMASTER_D !== 1'b0) begin errors++; $display("FAIL single_hmaster_d_k1: got %b expected 0", HMASTER_D); end
        checks++; if (HADDR !== 36'h200000000) begin errors++; $display("FAIL single_haddr: got %h expected 200000000", HADDR); end
        checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL single_htrans: got %b expected 10", HTRANS); end
        checks++; if (HWRITE !== 1'b1) begin errors++; $display("FAIL single_hwrite: got %b expected 1", HWRITE); end
        HADDR0 = 36'h0ABCDEF00;
        #1;
        checks++; if (HADDR !== 36'h200000000) begin errors++; $display("FAIL single_unselected: got %h expected 200000000", HADDR); end
        cyc();
        checks++; if (HMASTER_D !== 1'b1) begin errors++; $display("FAIL single_hmaster_d_k2: got %b expected 1", HMASTER_D); end
        checks++; if (HWDATA !== 64'hDEADBEEF_00000001) begin errors++; $display("FAIL single_hwdata: got %h expected deadbeef00000001", HWDATA); end
        HBUSREQ1 = 1'b0; HTRANS1 = 2'b00;
        cyc();
        checks++; if (HGRANT0 !== 1'b1) begin errors++; $display("FAIL single_park: got %b expected 1", HGRANT0); end
        cyc();
        checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL single_park_owner: got %b expected 0", HMASTER); end
    endtask

    task automatic test_contention();
        logic exp_g1;
        logic exp_m;
        do_reset();
        HBUSREQ0 = 1'b1; HBUSREQ1 = 1'b1;
        HTRANS0  = 2'b10; HTRANS1 = 2'b10; HBURST0 = 3'd0; HBURST1 = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            exp_g1 = (i % 2 == 0);
            exp_m  = (i % 2 == 1);
            checks++; if (HGRANT1 !== exp_g1) begin errors++; $display("FAIL contention_grant1[%0d]: got %b expected %b", i, HGRANT1, exp_g1); end
            checks++; if (HGRANT0 !== ~exp_g1) begin errors++; $display("FAIL contention_grant0[%0d]: got %b expected %b", i, HGRANT0, ~exp_g1); end
            checks++; if (HMASTER !== exp_m) begin errors++; $display("FAIL contention_hmaster[%0d]: got %b expected %b", i, HMASTER, exp_m); end
        end
        HBUSREQ0 = 1'b0; HBUSREQ1 = 1'b0; HTRANS0 = 2'b00; HTRANS1 = 2'b00;
    endtask

    task automatic test_burst();
        do_reset();
        HBUSREQ0 = 1'b1; HBUSREQ1 = 1'b1;
        HTRANS0  = 2'b10; HBURST0 = 3'b011; HADDR0 = 36'h000000100;
        cyc();
        checks++; if (HGRANT0 !== 1'b1) begin errors++; $display("FAIL burst_beat1: got %b expected 1", HGRANT0); end
        HTRANS0 = 2'b11; HADDR0 = 36'h000000108; HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (HGRANT0 !== 1'b1 || HMASTER !== 1'b0) begin errors++; $display("FAIL burst_wait[%0d]: got gnt0=%b owner=%b expected gnt0=1 owner=0", i, HGRANT0, HMASTER); end
        end
        HREADY = 1'b1;
        cyc();
        checks++; if (HGRANT0 !== 1'b1) begin errors++; $display("FAIL burst_beat2: got %b expected 1", HGRANT0); end
        HADDR0 = 36'h000000110;
        cyc();
        checks++; if (HGRANT0 !== 1'b1) begin errors++; $display("FAIL burst_beat3: got %b expected 1", HGRANT0); end
        HADDR0 = 36'h000000118;
        cyc();
        checks++; if (HGRANT1 !== 1'b1) begin errors++; $display("FAIL burst_beat4_grant1: got %b expected 1", HGRANT1); end
        checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL burst_beat4_owner: got %b expected 0", HMASTER); end
        HTRANS0 = 2'b00; HBUSREQ0 = 1'b0; HTRANS1 = 2'b10;
        cyc();
        checks++; if (HMASTER !== 1'b1) begin errors++; $display("FAIL burst_handover_owner: got %b expected 1", HMASTER); end
        HBUSREQ1 = 1'b0; HTRANS1 = 2'b00;
    endtask

    task automatic test_lock();
        do_reset();
        HBUSREQ0 = 1'b1; HBUSREQ1 = 1'b1; HLOCK1 = 1'b1;
        HTRANS1  = 2'b10; HBURST1 = 3'd0; HTRANS0 = 2'b00;
        cyc();
        checks++; if (HGRANT1 !== 1'b1) begin errors++; $display("FAIL lock_grant: got %b expected 1", HGRANT1); end
        checks++; if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL lock_pre_mastlock: got %b expected 0", HMASTLOCK); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (HGRANT1 !== 1'b1 || HGRANT0 !== 1'b0) begin errors++; $display("FAIL lock_hold[%0d]: got gnt1=%b gnt0=%b expected gnt1=1 gnt0=0", i, HGRANT1, HGRANT0); end
            checks++; if (HMASTLOCK !== 1'b1 || HMASTER !== 1'b1) begin errors++; $display("FAIL lock_phase[%0d]: got lock=%b owner=%b expected lock=1 owner=1", i, HMASTLOCK, HMASTER); end
        end
        HLOCK1 = 1'b0; HBUSREQ1 = 1'b0;
        cyc();
        checks++; if (HGRANT0 !== 1'b1) begin errors++; $display("FAIL lock_release_grant0: got %b expected 1", HGRANT0); end
        checks++; if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL lock_release_mastlock: got %b expected 0", HMASTLOCK); end
        HTRANS1 = 2'b00;
        cyc();
        checks++; if (HMASTER !== 1'b0) begin errors++; $display("FAIL lock_release_owner: got %b expected 0", HMASTER); end
        HBUSREQ0 = 1'b0;
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        HBUSREQ1 = 1'b1; HLOCK1 = 1'b1; HTRANS1 = 2'b10;
        cyc();
        cyc();
        SysRST = 1'b1;
        cyc();
        checks++; if (HGRANT0 !== 1'b1 || HMASTER !== 1'b0 || HMASTLOCK !== 1'b0) begin errors++; $display("FAIL reset_mid_lock: got gnt0=%b owner=%b lock=%b expected 1 0 0", HGRANT0, HMASTER, HMASTLOCK); end
        SysRST = 1'b0; HBUSREQ1 = 1'b0; HLOCK1 = 1'b0; HTRANS1 = 2'b00;
    endtask

    task automatic test_error();
        do_reset();
        HBUSREQ0 = 1'b1; HBUSREQ1 = 1'b1;
        HTRANS0  = 2'b10; HBURST0 = 3'b101; HADDR0 = 36'h000000200;
        cyc();
        checks++; if (HGRANT0 !== 1'b1) begin errors++; $display("FAIL error_beat1: got %b expected 1", HGRANT0); end
        HTRANS0 = 2'b11; HADDR0 = 36'h000000208;
        cyc();
        checks++; if (HGRANT0 !== 1'b1) begin errors++; $display("FAIL error_beat2: got %b expected 1", HGRANT0); end
        HADDR0 = 36'h000000210; HREADY = 1'b0; HRESP = 2'b01;
        cyc();
        checks++; if (HGRANT0 !== 1'b1) begin errors++; $display("FAIL error_stall_grant: got %b expected 1", HGRANT0); end
        HREADY = 1'b1; HTRANS0 = 2'b00;
        cyc();
        checks++; if (HGRANT1 !== 1'b1) begin errors++; $display("FAIL error_rearb_grant1: got %b expected 1", HGRANT1); end
        HRESP = 2'b00; HBUSREQ0 = 1'b0;
        cyc();
        checks++; if (HMASTER !== 1'b1) begin errors++; $display("FAIL error_rearb_owner: got %b expected 1", HMASTER); end
        HBUSREQ1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_contention();
        test_burst();
        test_lock();
        test_reset_mid_lock();
        test_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
